// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: N masters, M slaves, round-robin arbitration,
// masked upper-address decode, unmapped-address error and stalled-slave watchdog.
module wb_conbus_rr #(
  parameter int N_MASTERS   = 5,
  parameter int N_SLAVES    = 6,
  parameter int DECODE_BITS = 3,
  parameter logic [N_SLAVES*DECODE_BITS-1:0] S_ADDR = '0,
  parameter logic [N_SLAVES*DECODE_BITS-1:0] S_MASK = '1,
  parameter int TIMEOUT     = 255
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [32*N_MASTERS-1:0]   m_adr_i,
  input  logic [32*N_MASTERS-1:0]   m_dat_i,
  output logic [31:0]               m_dat_o,
  input  logic [3*N_MASTERS-1:0]    m_cti_i,
  input  logic [4*N_MASTERS-1:0]    m_sel_i,
  input  logic [N_MASTERS-1:0]      m_we_i,
  input  logic [N_MASTERS-1:0]      m_cyc_i,
  input  logic [N_MASTERS-1:0]      m_stb_i,
  output logic [N_MASTERS-1:0]      m_ack_o,
  output logic [N_MASTERS-1:0]      m_err_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [2:0]                s_cti_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  input  logic [32*N_SLAVES-1:0]    s_dat_i,
  output logic [N_SLAVES-1:0]       s_cyc_o,
  output logic [N_SLAVES-1:0]       s_stb_o,
  input  logic [N_SLAVES-1:0]       s_ack_i,
  output logic [N_MASTERS-1:0]      grant_o
);

  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e               state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [MW-1:0]        last_q;
  logic [MW-1:0]        nxt_idx;
  logic                 nxt_vld;

  logic [31:0]          g_adr, g_dat;
  logic [2:0]           g_cti;
  logic [3:0]           g_sel;
  logic                 g_we, g_cyc, g_stb;

  logic [DECODE_BITS-1:0] adr_hi;
  logic [N_SLAVES-1:0]  hit;
  logic                 mapped;
  logic                 sel_ack;

  logic [7:0]           cnt_q, cnt_d;
  logic                 ue_q, ue_d, ue_done_q, ue_done_d;
  logic                 wd_fire, err_any;

  // First requester after the last grantee, cyclically; the lowest offset wins.
  always_comb begin
    int idx;
    idx     = 0;
    nxt_idx = last_q;
    nxt_vld = 1'b0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N_MASTERS;
      if (m_cyc_i[idx]) begin
        nxt_idx = MW'(idx);
        nxt_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= MW'(N_MASTERS - 1);
    end else begin
      case (state_q)
        IDLE: if (nxt_vld) begin
          state_q <= OWNED;
          grant_q <= N_MASTERS'(1) << nxt_idx;
          last_q  <= nxt_idx;
        end
        OWNED: if (!g_cyc) begin
          if (nxt_vld) begin
            grant_q <= N_MASTERS'(1) << nxt_idx;
            last_q  <= nxt_idx;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_cti = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_adr = g_adr | m_adr_i[32*i +: 32];
        g_dat = g_dat | m_dat_i[32*i +: 32];
        g_cti = g_cti | m_cti_i[3*i +: 3];
        g_sel = g_sel | m_sel_i[4*i +: 4];
        g_we  = g_we  | m_we_i[i];
        g_cyc = g_cyc | m_cyc_i[i];
        g_stb = g_stb | m_stb_i[i];
      end
    end
  end

  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_cti_o = g_cti;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign adr_hi  = g_adr[31 -: DECODE_BITS];

  always_comb begin
    hit    = '0;
    mapped = 1'b0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (!mapped && ((adr_hi & S_MASK[j*DECODE_BITS +: DECODE_BITS]) ==
                      (S_ADDR[j*DECODE_BITS +: DECODE_BITS] & S_MASK[j*DECODE_BITS +: DECODE_BITS]))) begin
        hit[j] = 1'b1;
        mapped = 1'b1;
      end
    end
  end

  always_comb begin
    m_dat_o = '0;
    for (int j = 0; j < N_SLAVES; j++)
      if (hit[j]) m_dat_o = s_dat_i[32*j +: 32];
  end

  assign sel_ack = |(s_ack_i & hit);
  assign wd_fire = (TIMEOUT != 0) && g_cyc && g_stb && (cnt_q == 8'(TIMEOUT));
  // Ack always beats a pending error so the two are never seen together.
  assign err_any = (ue_q | wd_fire) & ~sel_ack;

  assign s_cyc_o = {N_SLAVES{g_cyc}} & hit;
  assign s_stb_o = {N_SLAVES{g_stb & ~wd_fire}} & hit;
  assign m_ack_o = {N_MASTERS{sel_ack}} & grant_q;
  assign m_err_o = {N_MASTERS{err_any}} & grant_q;

  // ue_done holds off repeat errors until the strobe has dropped for a cycle.
  assign ue_d      = g_cyc & g_stb & ~mapped & ~ue_q & ~ue_done_q;
  assign ue_done_d = (g_cyc & g_stb) ? (ue_done_q | ue_q) : 1'b0;
  assign cnt_d     = (sel_ack | err_any | wd_fire | ~(g_cyc & g_stb)) ? 8'd0 : cnt_q + 8'd1;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q     <= '0;
      ue_q      <= 1'b0;
      ue_done_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ue_q      <= ue_d;
      ue_done_q <= ue_done_d;
    end
  end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr: 5 masters, 2 slaves mapped at 000 and 011, TIMEOUT=4.
module tb_wb_conbus_rr;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic [159:0] m_adr, m_dat;
  logic [14:0]  m_cti;
  logic [19:0]  m_sel;
  logic [4:0]   m_we, m_cyc, m_stb;
  logic [31:0]  m_dat_o;
  logic [4:0]   m_ack_o, m_err_o, grant_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic [2:0]   s_cti_o;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic [63:0]  s_dat_i;
  logic [1:0]   s_cyc_o, s_stb_o, s_ack_i;
  logic         auto_ack;
  logic [1:0]   man_ack;
  int           total = 0;
  int           bad = 0;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;

  always #5 sys_clk = ~sys_clk;

  assign s_dat_i = {D1, D0};
  assign s_ack_i = auto_ack ? s_stb_o : man_ack;

  wb_conbus_rr #(
    .N_MASTERS(5), .N_SLAVES(2), .DECODE_BITS(3),
    .S_ADDR({3'b011, 3'b000}), .S_MASK(6'b111111), .TIMEOUT(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_cti_i(m_cti), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_dat_i(s_dat_i), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic [31:0] adr);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_adr[32*i +: 32] = adr;
  endtask

  initial begin
    int prev;
    logic [4:0] oh;
    sys_rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_cti = '0; m_sel = '0;
    m_we = '0; m_cyc = '0; m_stb = '0;
    auto_ack = 1'b0; man_ack = 2'b00;

    // 1: masters 0 and 2 request out of reset
    set_m(0, 1'b1, 1'b1, 32'h0000_0010);
    set_m(2, 1'b1, 1'b1, 32'h6000_0020);
    m_dat[31:0] = 32'hD0D0_0000; m_sel[3:0] = 4'hF; m_we[0] = 1'b1;
    tick(); tick();
    chk("rst_grant", grant_o, 5'b0);
    chk("rst_scyc", s_cyc_o, 2'b0);
    chk("rst_sstb", s_stb_o, 2'b0);
    chk("rst_ack", m_ack_o, 5'b0);
    chk("rst_err", m_err_o, 5'b0);
    chk("rst_sadr", s_adr_o, 32'h0);
    sys_rst_n = 1'b1;
    tick();
    chk("t1_grant0", grant_o, 5'b00001);
    chk("t1_scyc", s_cyc_o, 2'b01);
    chk("t1_sstb", s_stb_o, 2'b01);
    chk("t1_sadr", s_adr_o, 32'h0000_0010);
    chk("t1_sdat", s_dat_o, 32'hD0D0_0000);
    chk("t1_ssel", s_sel_o, 4'hF);
    chk("t1_swe", s_we_o, 1'b1);
    man_ack = 2'b01;
    #1;
    chk("t1_ack0", m_ack_o, 5'b00001);
    chk("t1_noerr", m_err_o, 5'b0);
    chk("t1_mdat0", m_dat_o, D0);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0000_0010);
    man_ack = 2'b00;
    #1;
    chk("t1_hold", grant_o, 5'b00001);
    chk("t1_scyc_drop", s_cyc_o, 2'b00);
    tick();
    chk("t1_grant2", grant_o, 5'b00100);
    chk("t1_scyc2", s_cyc_o, 2'b10);
    chk("t1_sadr2", s_adr_o, 32'h6000_0020);
    chk("t1_mdat1", m_dat_o, D1);
    set_m(2, 1'b0, 1'b0, 32'h6000_0020);
    tick();
    chk("t1_idle", grant_o, 5'b0);

    // 2: everyone requests, round-robin from master 0 after reset
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    auto_ack = 1'b1;
    m_cyc = 5'b11111; m_stb = 5'b11111;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      oh = 5'b00001 << (k % 5);
      tick();
      chk("t2_grant", grant_o, oh);
      chk("t2_ack", m_ack_o, oh);
      tick();
      m_cyc[k % 5] = 1'b0; m_stb[k % 5] = 1'b0;
      if (prev >= 0) begin m_cyc[prev] = 1'b1; m_stb[prev] = 1'b1; end
      prev = k % 5;
    end
    m_cyc = '0; m_stb = '0;
    tick(); tick();
    chk("t2_idle", grant_o, 5'b0);

    // 3: m1 burst to slave 0 while m0 waits
    set_m(0, 1'b1, 1'b1, 32'h0000_0100);
    set_m(1, 1'b1, 1'b1, 32'h0000_0200);
    m_cti[5:3] = 3'b010;
    tick();
    for (int b = 0; b < 4; b++) begin
      m_cti[5:3] = (b == 3) ? 3'b111 : 3'b010;
      #1;
      chk("t3_grant", grant_o, 5'b00010);
      chk("t3_ack", m_ack_o, 5'b00010);
      chk("t3_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    set_m(1, 1'b0, 1'b0, 32'h0000_0200);
    #1;
    chk("t3_hold", grant_o, 5'b00010);
    chk("t3_noack", m_ack_o, 5'b0);
    tick();
    chk("t3_grant0", grant_o, 5'b00001);
    chk("t3_ack0", m_ack_o, 5'b00001);
    set_m(0, 1'b0, 1'b0, 32'h0000_0100);
    tick(); tick();

    // 4: unmapped access by m3
    set_m(3, 1'b1, 1'b1, 32'h4000_0000);
    tick();
    chk("t4_grant", grant_o, 5'b01000);
    chk("t4_sstb", s_stb_o, 2'b00);
    chk("t4_scyc", s_cyc_o, 2'b00);
    chk("t4_err_g", m_err_o, 5'b0);
    chk("t4_mdat", m_dat_o, 32'h0);
    tick();
    chk("t4_err_g1", m_err_o, 5'b01000);
    chk("t4_noack", m_ack_o, 5'b0);
    tick();
    chk("t4_err_g2", m_err_o, 5'b0);
    m_stb[3] = 1'b0;
    tick();
    m_stb[3] = 1'b1;
    #1;
    chk("t4_err_restb", m_err_o, 5'b0);
    tick();
    chk("t4_err_again", m_err_o, 5'b01000);
    set_m(3, 1'b0, 1'b0, 32'h4000_0000);
    tick();
    chk("t4_idle", grant_o, 5'b0);

    // 5: watchdog on m4 with a silent slave 0
    auto_ack = 1'b0;
    set_m(4, 1'b1, 1'b1, 32'h0000_0040);
    tick();
    for (int d = 0; d < 4; d++) begin
      chk("t5_noerr", m_err_o, 5'b0);
      chk("t5_sstb", s_stb_o, 2'b01);
      tick();
    end
    chk("t5_wd_err", m_err_o, 5'b10000);
    chk("t5_wd_sstb", s_stb_o, 2'b00);
    chk("t5_wd_scyc", s_cyc_o, 2'b01);
    chk("t5_wd_noack", m_ack_o, 5'b0);
    tick();
    chk("t5_err_clr", m_err_o, 5'b0);
    chk("t5_sstb_back", s_stb_o, 2'b01);
    tick(); tick(); tick(); tick();
    chk("t5_fire2_sstb", s_stb_o, 2'b00);
    man_ack = 2'b01;
    #1;
    chk("t5_ackwins_ack", m_ack_o, 5'b10000);
    chk("t5_ackwins_err", m_err_o, 5'b0);
    tick();
    man_ack = 2'b00;
    tick(); tick(); tick();

    // 6: reset during the stall, then re-arbitrate from master 0
    sys_rst_n = 1'b0;
    set_m(0, 1'b1, 1'b1, 32'h0000_0000);
    set_m(2, 1'b1, 1'b1, 32'h6000_0000);
    tick();
    chk("t6_grant", grant_o, 5'b0);
    chk("t6_scyc", s_cyc_o, 2'b0);
    chk("t6_sstb", s_stb_o, 2'b0);
    chk("t6_err", m_err_o, 5'b0);
    sys_rst_n = 1'b1;
    tick();
    chk("t6_regrant", grant_o, 5'b00001);
    m_cyc = '0; m_stb = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_conbus_rr.md
# wb_conbus_rr

Parametrised shared-bus Wishbone interconnect joining N masters to M slaves. It supersedes the fixed 5x6 switch in SoC tops and adds:
- round-robin arbitration with grant held for the whole cycle (bursts and locked sequences);
- configurable per-slave address decode;
- a bus error on unmapped addresses;
- a watchdog error on stalled slaves.

All master and slave ports are flattened vectors; master i / slave j occupy slice i / j.

## Interface
Parameters:
- N_MASTERS, 5: number of masters, 1..8.
- N_SLAVES, 6: number of slaves, 1..8.
- DECODE_BITS, 3: number of upper address bits decoded, adr[31:32-DECODE_BITS].
- S_ADDR, 0: flattened N_SLAVES*DECODE_BITS match values; slave j uses slice j.
- S_MASK, all ones: flattened N_SLAVES*DECODE_BITS masks; slave j uses slice j.
- TIMEOUT, 255: stall cycles before a watchdog error; 0 disables the watchdog. Counter is 8 bits.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- m_adr_i  in  32*N_MASTERS  master addresses.
- m_dat_i  in  32*N_MASTERS  master write data.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_cti_i  in  3*N_MASTERS  cycle type identifiers.
- m_sel_i  in  4*N_MASTERS  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  N_MASTERS each  write enable, cycle, strobe.
- m_ack_o, m_err_o  out  N_MASTERS each  per-master acknowledge and error.
- s_adr_o  out  32  address of the grantee.
- s_dat_o  out  32  write data of the grantee.
- s_cti_o  out  3  cycle type of the grantee.
- s_sel_o  out  4  byte selects of the grantee.
- s_we_o  out  1  write enable of the grantee.
- s_dat_i  in  32*N_SLAVES  slave read data.
- s_cyc_o, s_stb_o  out  N_SLAVES each  one-hot per-slave cycle and strobe.
- s_ack_i  in  N_SLAVES  slave acknowledges.
- grant_o  out  N_MASTERS  one-hot registered grant; all zero when idle.

## Operation
Arbiter states:
- IDLE (grant_o = 0) moves to OWNED when any m_cyc_i is high.
- OWNED moves back to IDLE, or directly to the next requester, when the grantee's cyc falls.
- Next grantee is the first requesting master after the last grantee, in index order, cyclically.
- Reset sets the last-grantee pointer to N_MASTERS-1, so master 0 has first priority.
- Grant never changes while the grantee's cyc is high, whatever the cti value.

Shared bus signals:
- s_adr_o, s_dat_o, s_sel_o, s_we_o and s_cti_o are muxed from the grantee; they are zero when idle.
- m_dat_o is s_dat_i of the decoded slave; zero if no slave is decoded.

Decode:
- Slave j is hit when (adr_hi & S_MASK_j) == (S_ADDR_j & S_MASK_j).
- On overlapping matches the lowest j wins.
- s_cyc_o[j] = grantee cyc & hit_j.
- s_stb_o[j] = grantee stb & hit_j & ~wd_fire.

Acknowledge: m_ack_o[grantee] = s_ack_i of the decoded slave. Non-grantees never see ack or err.

Unmapped address:
- No slave is strobed.
- A registered flag raises m_err_o[grantee] for exactly one cycle, the cycle after stb is first seen.
- The flag then clears, and no further err is raised until stb has been low for at least one cycle.

Watchdog:
- 8-bit counter, cleared on ack, on err, or when the grantee's stb is low; otherwise it increments each cycle.
- When the counter equals TIMEOUT (TIMEOUT ≠ 0): wd_fire is asserted, m_err_o[grantee] pulses for that cycle, s_stb_o is forced low, and the counter clears.
- If ack arrives in the wd_fire cycle, ack wins: no err is raised and the counter clears.

Error exclusivity: ack and err are never high together for any master.

## Timing
- Reset values: grant_o = 0; all s_cyc_o, s_stb_o, m_ack_o and m_err_o = 0; counter = 0; unmapped flag = 0.
- Reset mid-transfer: at the first edge with sys_rst_n low, grant is dropped and all strobes fall on the same edge.
- Grant latency: cyc rises in cycle 0 on an idle bus → grant_o registered at edge 1 → slave sees cyc/stb in cycle 1.
- Grant turnaround: grantee cyc falls in cycle k → new grant valid in cycle k+1, with no idle gap if another master is requesting.
- Data path: combinational from grantee to slave and from slave back to masters; a zero-wait slave gives single-cycle ack once granted.
- Unmapped err: stb seen in cycle g → err in cycle g+1.
- Watchdog err: stb first seen in cycle g with no ack → err in cycle g+TIMEOUT.

## Test plan
1. Masters 0 and 2 both raise cyc from reset → grant 0 first; after m0 cyc falls, grant_o = 4'b0100 on the next cycle; 0 on the following cycle if m2 has also released.
2. All 5 masters request continuously, each releasing after one ack → grant order 0,1,2,3,4,0, with no master granted twice before the others.
3. m1 runs a 4-beat burst (cti=010, last beat 111) to slave 0, with m0 requesting throughout → grant stays on m1 for all 4 acks, then goes to m0.
4. S_ADDR/S_MASK map only 000 and 011; access to 0x4000_0000 → no s_stb_o, one-cycle m_err_o one cycle after stb, and no ack.
5. TIMEOUT=4 and slave never acks → err in cycle g+4 with s_stb_o low in that cycle; repeat with ack in cycle g+4 → ack and no err.
6. Pull sys_rst_n low during a stalled transfer → grant_o, s_cyc_o and m_err_o all 0 after the edge; after reset release the bus re-arbitrates from master 0.
